// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command decoder.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_ADDR,
    GET_DHI,
    GET_DLO,
    DRAIN
  } spi_cmd_state_t;

  localparam logic [7:0] CMD_WR      = 8'h01;
  localparam logic [7:0] CMD_RD      = 8'h02;
  localparam logic [7:0] STATUS_BYTE = 8'hA5;
  localparam int         FRAME_BYTES = 4;

endpackage

// File: rtl/spi_reg_file.sv
// NUM_REGS x 16-bit register file: one write port, combinational read,
// asynchronous active-low clear. reg[0] is exposed separately for the display.
module spi_reg_file
  import spi_cmd_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int AW       = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o,
  output logic [15:0]   reg0_o
);

  logic [15:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[raddr_i];
  assign reg0_o  = regs_q[0];

endmodule

// File: rtl/spi_cmd_decoder.sv
// Assembles 4-byte SPI command frames (CMD, ADDR, DATA_HI, DATA_LO) and
// executes register reads/writes. Optional error counter: SPI_CMD_ERRCNT_EN.
module spi_cmd_decoder #(
  parameter int         NUM_REGS    = 4,
  parameter logic [7:0] STATUS_BYTE = spi_cmd_pkg::STATUS_BYTE,
  parameter logic [7:0] CMD_WR      = spi_cmd_pkg::CMD_WR,
  parameter logic [7:0] CMD_RD      = spi_cmd_pkg::CMD_RD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_load,
  output logic [15:0] disp_value,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);
  import spi_cmd_pkg::*;

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  spi_cmd_state_t state_q, state_d;
  logic           cs_prev_q;
  logic           is_wr_q, is_wr_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           bad_q, bad_d;
  logic [7:0]     dhi_q, dhi_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           tx_load_q, tx_load_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           cs_fall, byte_ok, abort, addr_bad, wr_commit;
  logic           rx_errsel, errsel_cur;
  logic [AW-1:0]  rf_raddr;
  logic [15:0]    rf_rdata, rd_word;

  assign cs_fall  = cs_prev_q & ~cs_n;
  // cs_n high wins over a coincident rx_valid: the byte is dropped.
  assign byte_ok  = rx_valid & ~cs_n;
  assign abort    = cs_n & (state_q inside {GET_CMD, GET_ADDR, GET_DHI, GET_DLO});
  assign addr_bad = (32'(rx_byte) >= NUM_REGS) & ~rx_errsel;
  assign rf_raddr = (state_q == GET_ADDR) ? rx_byte[AW-1:0] : addr_q;
  assign wr_commit = (state_q == GET_DLO) & byte_ok & is_wr_q & ~bad_q;

`ifdef SPI_CMD_ERRCNT_EN
  logic [7:0] errcnt_q;
  logic       errsel_q;

  assign rx_errsel  = (32'(rx_byte) == NUM_REGS);
  assign errsel_cur = errsel_q;
  assign rd_word    = (((state_q == GET_ADDR) ? rx_errsel : errsel_q)) ?
                      {8'h00, errcnt_q} : rf_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      errsel_q <= 1'b0;
      errcnt_q <= '0;
    end else begin
      if ((state_q == GET_ADDR) && byte_ok) errsel_q <= rx_errsel;
      if (wr_commit && errsel_q)            errcnt_q <= '0;
      else if (err_d && errcnt_q != 8'hFF)  errcnt_q <= errcnt_q + 8'd1;
    end
  end
`else
  assign rx_errsel  = 1'b0;
  assign errsel_cur = 1'b0;
  assign rd_word    = rf_rdata;
`endif

  spi_reg_file #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_regs (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (wr_commit & ~errsel_cur),
    .waddr_i (addr_q),
    .wdata_i ({dhi_q, rx_byte}),
    .raddr_i (rf_raddr),
    .rdata_o (rf_rdata),
    .reg0_o  (disp_value)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cs_prev_q <= 1'b1;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      bad_q     <= 1'b0;
      dhi_q     <= '0;
      tx_byte_q <= '0;
      tx_load_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_prev_q <= cs_n;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      bad_q     <= bad_d;
      dhi_q     <= dhi_d;
      tx_byte_q <= tx_byte_d;
      tx_load_q <= tx_load_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    bad_d   = bad_q;
    dhi_d   = dhi_q;
    unique case (state_q)
      IDLE:     if (cs_fall) state_d = GET_CMD;
      GET_CMD: begin
        if (cs_n) state_d = IDLE;
        else if (rx_valid) begin
          if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
            is_wr_d = (rx_byte == CMD_WR);
            state_d = GET_ADDR;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      GET_ADDR: begin
        if (cs_n) state_d = IDLE;
        else if (rx_valid) begin
          addr_d  = rx_byte[AW-1:0];
          bad_d   = addr_bad;
          state_d = GET_DHI;
        end
      end
      GET_DHI: begin
        if (cs_n) state_d = IDLE;
        else if (rx_valid) begin
          dhi_d   = rx_byte;
          state_d = GET_DLO;
        end
      end
      GET_DLO: begin
        if (cs_n) state_d = IDLE;
        else if (rx_valid) state_d = DRAIN;
      end
      DRAIN:    if (cs_n) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_byte_d = tx_byte_q;
    tx_load_d = 1'b0;
    done_d    = 1'b0;
    err_d     = abort;
    if (!abort) begin
      unique case (state_q)
        IDLE: if (cs_fall) begin
          tx_byte_d = STATUS_BYTE;
          tx_load_d = 1'b1;
        end
        GET_CMD: if (byte_ok && rx_byte != CMD_WR && rx_byte != CMD_RD) err_d = 1'b1;
        GET_ADDR: if (byte_ok && !is_wr_q) begin
          tx_byte_d = addr_bad ? 8'hFF : rd_word[15:8];
          tx_load_d = 1'b1;
        end
        GET_DHI: if (byte_ok && !is_wr_q) begin
          tx_byte_d = bad_q ? 8'hFF : rd_word[7:0];
          tx_load_d = 1'b1;
        end
        GET_DLO: if (byte_ok) begin
          done_d = ~bad_q;
          err_d  = bad_q;
        end
        default: ;
      endcase
    end
  end

  assign tx_byte    = tx_byte_q;
  assign tx_load    = tx_load_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != IDLE);

endmodule
